syscall_unit: RTL and testbench
===============================

SYSCALL_UNIT -- requirements
Module: syscall_unit

Interface
REQ-001 The block SHALL have the ports below, one line each as: name  direction  width  meaning.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 syscall  in  1  level from decoder; high while the current instruction is SYSCALL.
REQ-005 v0  in  32  register file $2 value (service code).
REQ-006 a0  in  32  register file $4 value (argument).
REQ-007 stall  out  1  freezes PC and register-file writes while high.
REQ-008 halt  out  1  sticky; program has executed exit.
REQ-009 err  out  1  one-cycle pulse on an unsupported service code.
REQ-010 tx_data  out  8  output byte (ASCII).
REQ-011 tx_valid  out  1  tx_data is valid.
REQ-012 tx_ready  in  1  sink accepts the byte.

Function
REQ-013 The state machine SHALL have the states IDLE, CONV, EMIT, DONE and HALT.
REQ-014 In IDLE with syscall=1, the block SHALL latch v0 and a0 and dispatch on the latched v0:
- 11 (print char): go to EMIT.
- 1 (print int): go to CONV.
- 10 (exit): go to HALT.
- any other value: pulse err and go to DONE.
REQ-015 stall SHALL equal (syscall AND state!=DONE) OR state==HALT, and SHALL be combinational so that it is already high in the first IDLE cycle.
REQ-016 DONE SHALL last exactly one cycle, with stall=0 so the PC advances, and SHALL return to IDLE; a back-to-back SYSCALL is then seen fresh.
REQ-017 Print char SHALL emit exactly one byte, a0[7:0].
REQ-018 Print int treats a0 as signed two's complement:
- if a0[31]=1, the magnitude SHALL be the 32-bit unsigned negation of a0; 0x80000000 therefore gives 2147483648.
- CONV SHALL run double-dabble for exactly 32 cycles into 10 BCD digits.
REQ-019 EMIT for print int SHALL send the bytes in this order:
- 0x2D ('-') if the value is negative;
- then the decimal digits, most significant first, each as 0x30+digit;
- leading zeros suppressed, but at least one digit sent (a0=0 gives "0").
REQ-020 Handshake: a byte transfers on a rising edge where tx_valid=1 and tx_ready=1.
- tx_valid SHALL NOT depend combinationally on tx_ready.
- Once tx_valid is high, tx_valid and tx_data SHALL hold until the transfer.
REQ-021 After the last byte transfers, the block SHALL go to DONE on the next cycle.
REQ-022 Latency with tx_ready tied high: print char SHALL give stall=1 for 2 cycles (IDLE, EMIT) and then DONE.
REQ-023 Latency with tx_ready tied high: print int SHALL give stall=1 for 1+32+N cycles, where N is the byte count, and then DONE.
REQ-024 HALT SHALL be terminal until reset, with halt=1, stall=1 and tx_valid=0; syscall SHALL be ignored in HALT.
REQ-025 v0 and a0 changing after the IDLE latch SHALL NOT affect the operation in progress.
REQ-026 tx_ready being high while tx_valid=0 SHALL have no effect.

Reset
REQ-027 rst SHALL have priority over all other inputs, including mid-CONV, mid-EMIT and HALT.
REQ-028 The cycle after rst is sampled high, the block SHALL be in IDLE with halt=0, err=0, tx_valid=0, tx_data=0x00 and all latches cleared; stall then follows REQ-015.
REQ-029 An aborted transfer SHALL NOT resume after reset.

Structure
REQ-030 Package syscall_pkg SHALL hold:
- the service codes (1, 10, 11);
- the state encoding;
- the ASCII constants 0x30 and 0x2D;
- the BCD digit count (10).
REQ-031 The double-dabble converter SHALL be a sub-module bin2bcd_seq with these ports:
- inputs: start, 32-bit value;
- outputs: busy, 40-bit BCD;
- behaviour: 32-cycle latency from start.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- v0=11, a0=0x00000041, tx_ready=1 -> one byte 0x41; stall high 2 cycles; err=0.
- v0=1, a0=0 -> exactly one byte 0x30; no 0x2D.
- v0=1, a0=0xFFFFFF85 -> bytes 0x2D,0x31,0x32,0x33.
- v0=1, a0=0x80000000, tx_ready toggling each cycle -> the 11 bytes "-2147483648"; tx_data stable while tx_valid=1 and tx_ready=0.
- v0=10 -> halt=1 and stall=1 persist through further syscalls; rst -> halt=0, stall=0.
- v0=5 -> err high exactly 1 cycle and no tx_valid; separately, rst during CONV -> tx_valid=0 afterwards and no bytes.

Source files
------------

// File: rtl/syscall_pkg.sv
// Shared constants, state encoding and BCD helpers
// for the SYSCALL service unit.
package syscall_pkg;

   localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
   localparam logic [31:0] SVC_EXIT       = 32'd10;
   localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;

   localparam int BCD_DIGITS = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_EMIT,
      S_DONE,
      S_HALT
   } state_t;

   // One double-dabble step: correct digits >= 5, then shift in a bit.
   function automatic logic [39:0] dd_step(
      input logic [39:0] b,
      input logic        bit_in
   );
      logic [39:0] t;
      t = b;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (t[4*i +: 4] >= 4'd5)
            t[4*i +: 4] = t[4*i +: 4] + 4'd3;
      end
      return {t[38:0], bit_in};
   endfunction

   function automatic logic [3:0] msd_index(
      input logic [39:0] b
   );
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (b[4*i +: 4] != 4'd0)
            idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/syscall_unit_if.sv
// Byte-stream valid/ready link from the syscall
// unit to an output sink.
interface syscall_unit_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/syscall_unit_bin2bcd_seq.sv
// Sequential 32-bit binary to 10-digit BCD converter,
// one double-dabble step per cycle, 32 steps total.
module bin2bcd_seq
   import syscall_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] value,
   output logic        busy,
   output logic [39:0] bcd
);

   logic [31:0] shreg;
   logic [4:0]  cnt;

   // The start edge performs step 1, so busy covers steps 2..32.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy  <= 1'b0;
         bcd   <= '0;
         shreg <= '0;
         cnt   <= '0;
      end else if (start) begin
         bcd   <= dd_step(40'd0, value[31]);
         shreg <= value << 1;
         cnt   <= 5'd1;
         busy  <= 1'b1;
      end else if (busy) begin
         bcd   <= dd_step(bcd, shreg[31]);
         shreg <= shreg << 1;
         cnt   <= cnt + 5'd1;
         if (cnt == 5'd31)
            busy <= 1'b0;
      end
   end

endmodule

// File: rtl/syscall_unit.sv
// SYSCALL service unit: print char, print int,
// exit, and error on unknown service codes.
module syscall_unit
   import syscall_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           syscall,
   input  logic [31:0]    v0,
   input  logic [31:0]    a0,
   output logic           stall,
   output logic           halt,
   output logic           err,
   syscall_unit_if.master tx
);

   state_t state, state_nxt;

   logic        dispatch;
   logic        svc_char;
   logic        svc_int;
   logic        svc_exit;
   logic        conv_start;
   logic        conv_busy;
   logic [39:0] bcd;
   logic [31:0] mag;

   logic        char_q;
   logic [7:0]  byte_q;
   logic        neg_pend;
   logic [3:0]  idx;
   logic        err_q;

   logic [3:0]  digit;
   logic [7:0]  cur_byte;
   logic        xfer;
   logic        last_byte;

   assign svc_char   = v0 == SVC_PRINT_CHAR;
   assign svc_int    = v0 == SVC_PRINT_INT;
   assign svc_exit   = v0 == SVC_EXIT;
   assign dispatch   = (state == S_IDLE) && syscall;
   assign conv_start = dispatch && svc_int;
   assign mag        = a0[31] ? 32'd0 - a0 : a0;

   bin2bcd_seq u_b2b (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .value (mag),
      .busy  (conv_busy),
      .bcd   (bcd)
   );

   assign digit    = 4'(bcd >> {idx, 2'b00});
   assign cur_byte = char_q   ? byte_q :
                     neg_pend ? ASCII_MINUS :
                     ASCII_ZERO + {4'h0, digit};

   assign tx.tx_valid = state == S_EMIT;
   assign tx.tx_data  = tx.tx_valid ? cur_byte : 8'h00;

   assign xfer      = tx.tx_valid && tx.tx_ready;
   assign last_byte = char_q || (!neg_pend && idx == 4'd0);

   assign stall = (syscall && state != S_DONE) ||
                  state == S_HALT;
   assign halt  = state == S_HALT;
   assign err   = err_q;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (syscall) begin
               unique case (1'b1)
                  svc_char: state_nxt = S_EMIT;
                  svc_int:  state_nxt = S_CONV;
                  svc_exit: state_nxt = S_HALT;
                  default:  state_nxt = S_DONE;
               endcase
            end
         end
         S_CONV: if (!conv_busy) state_nxt = S_EMIT;
         S_EMIT: if (xfer && last_byte) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Byte sequencing: optional sign, then digits from the MSD down.
   always_ff @(posedge clk) begin
      if (rst) begin
         char_q   <= 1'b0;
         byte_q   <= '0;
         neg_pend <= 1'b0;
         idx      <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= dispatch &&
                  !(svc_char || svc_int || svc_exit);
         if (dispatch) begin
            char_q   <= svc_char;
            byte_q   <= a0[7:0];
            neg_pend <= svc_int && a0[31];
            idx      <= '0;
         end
         if (state == S_CONV && !conv_busy)
            idx <= msd_index(bcd);
         if (xfer && !char_q) begin
            if (neg_pend)
               neg_pend <= 1'b0;
            else if (idx != 4'd0)
               idx <= idx - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_syscall_unit.sv
// Randomised bench for syscall_unit against a
// decimal-string reference model.
module tb_syscall_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        syscall;
   logic [31:0] v0;
   logic [31:0] a0;
   logic        stall;
   logic        halt;
   logic        err;

   syscall_unit_if tx_bus ();

   syscall_unit dut (
      .clk     (clk),
      .rst     (rst),
      .syscall (syscall),
      .v0      (v0),
      .a0      (a0),
      .stall   (stall),
      .halt    (halt),
      .err     (err),
      .tx      (tx_bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0] exp_q[$];

   task automatic chk(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] want
   );
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h",
                  tag, got, want);
      end
   endtask

   // Expected output bytes from the service rules.
   task automatic model(
      input logic [31:0] v,
      input logic [31:0] a
   );
      longint     mag;
      logic [7:0] dq[$];
      exp_q = {};
      if (v == 32'd11) begin
         exp_q.push_back(a[7:0]);
      end else if (v == 32'd1) begin
         if (a[31]) begin
            mag = 64'h1_0000_0000 - longint'(a);
            exp_q.push_back(8'h2D);
         end else begin
            mag = longint'(a);
         end
         if (mag == 0) dq.push_back(8'h30);
         while (mag != 0) begin
            dq.push_front(8'(48 + mag % 10));
            mag = mag / 10;
         end
         foreach (dq[i]) exp_q.push_back(dq[i]);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      syscall = 1'b0;
      tx_bus.tx_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_halt", 64'(halt), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_valid", 64'(tx_bus.tx_valid), 64'd0);
      chk("rst_data", 64'(tx_bus.tx_data), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
   endtask

   // mode 0: ready high, 1: toggling, 2: random
   task automatic run_op(
      input logic [31:0] v,
      input logic [31:0] a,
      input int          mode
   );
      logic [7:0] got_q[$];
      int         stalls = 0;
      int         early_err = 0;
      bit         done = 0;
      logic       hold = 0;
      logic [7:0] hold_d = 8'h00;
      int         exp_st;
      bit         bad_svc;
      model(v, a);
      bad_svc = !(v == 1 || v == 10 || v == 11);
      @(negedge clk);
      v0 = v;
      a0 = a;
      syscall = 1'b1;
      for (int c = 0; c < 400 && !done; c++) begin
         if (c > 0) begin
            v0 = $urandom;
            a0 = $urandom;
         end
         case (mode)
            0: tx_bus.tx_ready = 1'b1;
            1: tx_bus.tx_ready = c[0];
            default: tx_bus.tx_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (hold) begin
            chk("hold_valid",
                64'(tx_bus.tx_valid), 64'd1);
            chk("hold_data",
                64'(tx_bus.tx_data), 64'(hold_d));
         end
         if (!stall) begin
            done = 1;
            chk("err_done", 64'(err), 64'(bad_svc));
         end else begin
            stalls++;
            if (err) early_err++;
            if (tx_bus.tx_valid && tx_bus.tx_ready)
               got_q.push_back(tx_bus.tx_data);
            hold   = tx_bus.tx_valid && !tx_bus.tx_ready;
            hold_d = tx_bus.tx_data;
            @(negedge clk);
         end
      end
      syscall = 1'b0;
      if (!done) chk("timeout", 64'd0, 64'd1);
      chk("err_early", 64'(early_err), 64'd0);
      if (v == 11)      exp_st = 2;
      else if (v == 1)  exp_st = 33 + exp_q.size();
      else              exp_st = 1;
      if (mode == 0)
         chk("stall_cycles", 64'(stalls), 64'(exp_st));
      chk("byte_count", 64'(got_q.size()),
          64'(exp_q.size()));
      foreach (exp_q[i]) begin
         if (i < got_q.size())
            chk("byte", 64'(got_q[i]), 64'(exp_q[i]));
      end
   endtask

   task automatic run_exit();
      @(negedge clk);
      v0 = 32'd10;
      a0 = $urandom;
      syscall = 1'b1;
      tx_bus.tx_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         syscall = 1'($urandom_range(0, 1));
         v0 = 32'd11;
         #1;
         chk("halt", 64'(halt), 64'd1);
         chk("halt_stall", 64'(stall), 64'd1);
         chk("halt_valid", 64'(tx_bus.tx_valid), 64'd0);
      end
   endtask

   task automatic run_conv_abort();
      int seen = 0;
      @(negedge clk);
      v0 = 32'd1;
      a0 = 32'd12345;
      syscall = 1'b1;
      tx_bus.tx_ready = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      syscall = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         #1;
         if (tx_bus.tx_valid) seen++;
      end
      chk("abort_valid", 64'(seen), 64'd0);
   endtask

   initial begin
      logic [31:0] rv;
      logic [31:0] ra;
      int          sel;
      rst = 1'b1;
      syscall = 1'b0;
      v0 = '0;
      a0 = '0;
      tx_bus.tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      run_op(32'd11, 32'h0000_0041, 0);
      run_op(32'd1, 32'h0000_0000, 0);
      run_op(32'd1, 32'hFFFF_FF85, 0);
      run_op(32'd1, 32'h8000_0000, 1);
      run_op(32'd5, 32'h1234_5678, 0);
      run_exit();
      do_reset();
      run_conv_abort();
      run_op(32'd1, 32'd4294967, 0);

      for (int k = 0; k < 40; k++) begin
         sel = $urandom_range(0, 4);
         ra  = $urandom;
         if (sel == 0) ra = ra & 32'h0000_00FF;
         case (sel)
            0, 1: rv = 32'd1;
            2, 3: rv = 32'd11;
            default: begin
               rv = $urandom;
               if (rv == 1 || rv == 10 || rv == 11)
                  rv = 32'd7;
            end
         endcase
         run_op(rv, ra, $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
